// File: rtl/runway_pkg.sv
// runway_pkg: lamp-pattern mode type and wind-switch decoder shared by the runway lights generator.
package runway_pkg;

    typedef enum logic [1:0] {MODE_CALM, MODE_M2L, MODE_L2M} mode_e;

    function automatic mode_e decode_wind(input logic [1:0] w);
        return (w == 2'b10) ? MODE_M2L : (w == 2'b01) ? MODE_L2M : MODE_CALM;
    endfunction

endpackage

// File: rtl/step_prescaler.sv
// step_prescaler: counts STEP_DIV clocks per pattern step; the count freezes while pause is high.
module step_prescaler #(
    parameter int STEP_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic pause,
    output logic step
);
    localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    logic [CW-1:0] cnt;

    assign step = (cnt == CW'(STEP_DIV - 1)) && !pause;

    always_ff @(posedge clk) begin
        if (!reset)
            cnt <= '0;
        else if (step)
            cnt <= '0;
        else if (!pause)
            cnt <= cnt + CW'(1);
    end
endmodule

// File: rtl/runway_lights_gen.sv
// runway_lights_gen: calm / MSB->LSB / LSB->MSB runway lamp pattern generator with pause and frame-wrap pulse.
// Define RUNWAY_TRAIL_EN to also light the lamp the directional head has just left.
module runway_lights_gen
    import runway_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int STEP_DIV = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       wind,
    input  logic             pause,
    output logic [WIDTH-1:0] out,
    output logic             frame_start
);
    localparam int FW = $clog2(WIDTH);
    localparam int H  = (WIDTH + 1) / 2;
    localparam int LO = (WIDTH - 1) / 2;
    localparam int HI = WIDTH / 2;
    localparam logic [WIDTH-1:0] CALM0 = (WIDTH'(1) << LO) | (WIDTH'(1) << HI);

    mode_e           mode, next_mode;
    logic [FW-1:0]   frame, next_frame;
    logic [WIDTH-1:0] lamps;
    logic            step, wrap;
    int              k;

    step_prescaler #(.STEP_DIV(STEP_DIV)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .pause (pause),
        .step  (step)
    );

    // Lamps are decoded from the frame about to be loaded so out stays a pure register.
    always_comb begin
        next_mode  = decode_wind(wind);
        wrap       = int'(frame) == ((mode == MODE_CALM) ? H - 1 : WIDTH - 1);
        next_frame = (next_mode != mode || wrap) ? '0 : frame + FW'(1);
        k          = int'(next_frame);
        lamps      = '0;
        for (int i = 0; i < WIDTH; i++) begin
            lamps[i] = (next_mode == MODE_CALM) ? (i == LO - k || i == HI + k) :
                       (next_mode == MODE_M2L)  ? (i == WIDTH - 1 - k) : (i == k);
`ifdef RUNWAY_TRAIL_EN
            lamps[i] = lamps[i] | (k != 0 && ((next_mode == MODE_M2L && i == WIDTH - k) ||
                                              (next_mode == MODE_L2M && i == k - 1)));
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mode        <= MODE_CALM;
            frame       <= '0;
            out         <= CALM0;
            frame_start <= 1'b0;
        end else if (step) begin
            mode        <= next_mode;
            frame       <= next_frame;
            out         <= lamps;
            frame_start <= (next_frame == '0);
        end else begin
            frame_start <= 1'b0;
        end
    end
endmodule

// File: tb/tb_runway_lights_gen.sv
// tb_runway_lights_gen: scoreboard bench; stimulus queues cycle-tagged expectations, a negedge monitor checks them.
module tb_runway_lights_gen;

    typedef struct {
        int         cyc;
        int         dut;
        logic [7:0] out;
        logic       fs;
        string      name;
    } exp_t;

    logic       clk = 0;
    logic       reset = 0, pause = 0;
    logic [1:0] wind = 2'b00;
    logic [7:0] out8;
    logic       fs8;
    logic       reset3 = 0, pause3 = 0;
    logic [1:0] wind3 = 2'b00;
    logic [2:0] out3;
    logic       fs3;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t q[$];

    runway_lights_gen #(.WIDTH(8), .STEP_DIV(4)) dut8 (
        .clk(clk), .reset(reset), .wind(wind), .pause(pause), .out(out8), .frame_start(fs8)
    );

    runway_lights_gen #(.WIDTH(3), .STEP_DIV(1)) dut3 (
        .clk(clk), .reset(reset3), .wind(wind3), .pause(pause3), .out(out3), .frame_start(fs3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            logic [7:0] a_out;
            logic a_fs;
            e     = q.pop_front();
            a_out = (e.dut == 3) ? {5'b0, out3} : out8;
            a_fs  = (e.dut == 3) ? fs3 : fs8;
            checks++;
            if (e.cyc != cyc || a_out !== e.out || a_fs !== e.fs) begin
                failures++;
                $display("FAIL %s cyc=%0d(exp %0d): out=%h fs=%b, expected out=%h fs=%b",
                         e.name, cyc, e.cyc, a_out, a_fs, e.out, e.fs);
            end
        end
    end

    task automatic push(input int c, input int d, input logic [7:0] o, input logic f, input string n);
        exp_t e;
        e.cyc = c; e.dut = d; e.out = o; e.fs = f; e.name = n;
        q.push_back(e);
    endtask

    task automatic tick_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [7:0] m2l;
        // 1: reset then calm cycle
        push(1, 8, 8'h18, 0, "reset_c1");
        push(2, 8, 8'h18, 0, "reset_c2");
        tick_to(2);
        reset = 1;
        push(5, 8, 8'h18, 0, "calm_hold");
        push(6, 8, 8'h24, 0, "calm_f1");
        push(7, 8, 8'h24, 0, "calm_f1_hold");
        push(10, 8, 8'h42, 0, "calm_f2");
        push(14, 8, 8'h81, 0, "calm_f3");
        push(18, 8, 8'h18, 1, "calm_wrap");
        push(19, 8, 8'h18, 0, "calm_fs_clear");
        tick_to(18);
        // 2: MSB->LSB walk and wrap
        wind = 2'b10;
        for (int j = 0; j <= 8; j++) begin
            m2l = 8'h80 >> (j % 8);
            push(22 + 4 * j, 8, m2l, (j == 0 || j == 8), "m2l_walk");
        end
        tick_to(54);
        // 3: LSB->MSB, then switch back; wind glitches between steps ignored
        wind = 2'b01;
        push(58, 8, 8'h01, 1, "l2m_enter");
        push(62, 8, 8'h02, 0, "l2m_f1");
        push(66, 8, 8'h04, 0, "l2m_f2");
        push(70, 8, 8'h08, 0, "l2m_f3");
        push(74, 8, 8'h10, 0, "l2m_f4");
        push(75, 8, 8'h10, 0, "wind_toggle_a");
        push(76, 8, 8'h10, 0, "wind_toggle_b");
        push(77, 8, 8'h10, 0, "wind_toggle_c");
        push(78, 8, 8'h80, 1, "l2m_to_m2l");
        tick_to(74);
        wind = 2'b10; tick_to(75);
        wind = 2'b00; tick_to(76);
        wind = 2'b11; tick_to(77);
        wind = 2'b10; tick_to(80);
        // 4: pause at cnt=2 for 10 cycles
        pause = 1;
        for (int c = 81; c <= 90; c++) push(c, 8, 8'h80, 0, "paused_hold");
        push(91, 8, 8'h80, 0, "resume_cnt3");
        push(92, 8, 8'h40, 0, "resume_step");
        push(96, 8, 8'h20, 0, "m2l_0x20");
        push(100, 8, 8'h10, 0, "m2l_0x10");
        push(104, 8, 8'h08, 0, "m2l_0x08");
        tick_to(90);
        pause = 0;
        tick_to(104);
        // 5: reset mid-pattern while paused
        pause = 1;
        reset = 0;
        push(105, 8, 8'h18, 0, "midreset");
        tick_to(105);
        reset = 1;
        pause = 0;
        push(108, 8, 8'h18, 0, "post_reset_hold");
        push(109, 8, 8'h80, 1, "post_reset_mode_calm");
        tick_to(110);
        // 6: WIDTH=3, STEP_DIV=1
        push(110, 3, 8'b010, 0, "w3_reset");
        reset3 = 1;
        push(111, 3, 8'b101, 0, "w3_calm_f1");
        push(112, 3, 8'b010, 1, "w3_calm_wrap");
        tick_to(112);
        wind3 = 2'b10;
        push(113, 3, 8'b100, 1, "w3_m2l_f0");
`ifdef RUNWAY_TRAIL_EN
        push(114, 3, 8'b110, 0, "w3_m2l_f1");
        push(115, 3, 8'b011, 0, "w3_m2l_f2");
`else
        push(114, 3, 8'b010, 0, "w3_m2l_f1");
        push(115, 3, 8'b001, 0, "w3_m2l_f2");
`endif
        push(116, 3, 8'b100, 1, "w3_m2l_wrap");
        tick_to(118);
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
